// File: rtl/doodle_pkg.sv
`default_nettype none
// ============================================================================
// Package   : doodle_pkg
// Purpose   : Shared types and constants for the platform scheduler.
// Revision  : 1.0
// ============================================================================
package doodle_pkg;

    typedef logic [8:0] coord_t;

    typedef enum logic [1:0] {
        DIFF_EASY   = 2'd0,
        DIFF_MEDIUM = 2'd1,
        DIFF_HARD   = 2'd2,
        DIFF_HARD_X = 2'd3
    } difficulty_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/plat_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : plat_scheduler_if
// Purpose   : Frame control inputs and slot coordinate outputs of the scheduler.
// Revision  : 1.0
// ============================================================================
interface plat_scheduler_if #(
    parameter int NUM_PLAT = 16
);
    logic                  frame_clk;
    logic                  start;
    logic [5:0]            scroll;
    logic [1:0]            difficulty;
    logic [NUM_PLAT*9-1:0] plat_x;
    logic [NUM_PLAT*9-1:0] plat_y;
    logic [NUM_PLAT-1:0]   plat_valid;
    logic [11:0]           score;
    logic                  busy;
    logic                  frame_done;
    logic                  overrun;

    modport master (
        output frame_clk, start, scroll, difficulty,
        input  plat_x, plat_y, plat_valid, score, busy, frame_done, overrun
    );

    modport slave (
        input  frame_clk, start, scroll, difficulty,
        output plat_x, plat_y, plat_valid, score, busy, frame_done, overrun
    );
endinterface
`default_nettype wire

// File: rtl/plat_lfsr.sv
`default_nettype none
// ============================================================================
// Module    : plat_lfsr
// Purpose   : 16-bit Fibonacci LFSR with synchronous seed load and step enable.
// Revision  : 1.0
// ============================================================================
module plat_lfsr
    import doodle_pkg::*;
(
    input  wire logic        Clk,
    input  wire logic        Reset_n,
    input  wire logic        step,
    input  wire logic        load,
    output logic [15:0]      value
);
    logic [15:0] r_lfsr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_lfsr <= LFSR_SEED;
        else if (load)
            r_lfsr <= LFSR_SEED;
        else if (step)
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end

    assign value = r_lfsr;
endmodule
`default_nettype wire

// File: rtl/plat_scheduler.sv
`default_nettype none
// ============================================================================
// Module    : plat_scheduler
// Purpose   : Scrolls and respawns the platform slots once per video frame.
//             Optional PLAT_SKIP_EN leaves some respawned slots empty.
// Revision  : 1.0
// ============================================================================
module plat_scheduler
    import doodle_pkg::*;
#(
    parameter int NUM_PLAT   = 16,
    parameter int Y_BOTTOM   = 479,
    parameter int GAP        = 30,
    parameter int X_MAX      = 447,
    parameter int MAX_SCROLL = 31
) (
    input  wire logic        Clk,
    input  wire logic        Reset_n,
    plat_scheduler_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_PLAT);
    localparam int SCR_W = $clog2(MAX_SCROLL + 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_PLAT - 1);

    sched_state_t     r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_fc_sync;
    logic             r_fc_prev;
    logic             w_frame_evt;
    logic [SCR_W-1:0] r_scroll;
    logic [SCR_W-1:0] w_scroll_sat;
    coord_t           r_x [NUM_PLAT];
    coord_t           r_y [NUM_PLAT];
    logic [NUM_PLAT-1:0] r_valid;
    logic [11:0]      r_score;
    logic             r_overrun;
    logic [15:0]      w_lfsr;
    logic             w_lfsr_step;
    logic             w_busy;
    logic [9:0]       w_t;
    logic             w_wrap;
    coord_t           w_r, w_new_x, w_init_y;
    logic             w_resp_valid;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fc_sync <= 2'b00;
            r_fc_prev <= 1'b0;
        end else begin
            r_fc_sync <= {r_fc_sync[0], bus.frame_clk};
            r_fc_prev <= r_fc_sync[1];
        end
    end
    assign w_frame_evt = r_fc_prev & ~r_fc_sync[1];

    assign w_busy       = (r_state == ST_INIT) || (r_state == ST_UPDATE) || (r_state == ST_DONE);
    assign w_scroll_sat = (bus.scroll > 6'(MAX_SCROLL)) ? SCR_W'(MAX_SCROLL) : bus.scroll[SCR_W-1:0];
    assign w_t          = {1'b0, r_y[r_idx]} + 10'(r_scroll);
    assign w_wrap       = (w_t > 10'(Y_BOTTOM));
    assign w_r          = w_lfsr[8:0];
    assign w_new_x      = (w_r <= coord_t'(X_MAX)) ? w_r : w_r - coord_t'(X_MAX + 1);
    assign w_init_y     = coord_t'(Y_BOTTOM + 1 - GAP * (32'(r_idx) + 1));
    assign w_lfsr_step  = !bus.start && ((r_state == ST_INIT) || ((r_state == ST_UPDATE) && w_wrap));

    plat_lfsr u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .step    (w_lfsr_step),
        .load    (bus.start),
        .value   (w_lfsr)
    );

`ifdef PLAT_SKIP_EN
    logic r_skip;
    logic w_skip_cand;
    logic w_unused_lfsr;

    always_comb begin
        w_skip_cand = 1'b0;
        case (difficulty_t'(bus.difficulty))
            DIFF_EASY:   w_skip_cand = 1'b0;
            DIFF_MEDIUM: w_skip_cand = (w_lfsr[15:14] == 2'b00);
            default:     w_skip_cand = ~w_lfsr[15];
        endcase
    end
    // A skip is never allowed twice in a row so the player always has a foothold
    assign w_resp_valid  = !w_skip_cand || r_skip;
    assign w_unused_lfsr = ^w_lfsr[13:9];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_skip <= 1'b0;
        else if (bus.start)
            r_skip <= 1'b0;
        else if ((r_state == ST_UPDATE) && w_wrap)
            r_skip <= !w_resp_valid;
    end
`else
    logic w_unused_bits;
    assign w_resp_valid  = 1'b1;
    assign w_unused_bits = ^{bus.difficulty, w_lfsr[15:9]};
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.start) begin
            w_next = ST_INIT;
        end else begin
            case (r_state)
                ST_IDLE:   w_next = ST_IDLE;
                ST_INIT:   if (r_idx == c_last_idx) w_next = ST_WAIT;
                ST_WAIT:   if (w_frame_evt) w_next = ST_UPDATE;
                ST_UPDATE: if (r_idx == c_last_idx) w_next = ST_DONE;
                ST_DONE:   w_next = ST_WAIT;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_idx     <= '0;
            r_scroll  <= '0;
            r_valid   <= '0;
            r_score   <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else if (bus.start) begin
            r_idx     <= '0;
            r_score   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_frame_evt && w_busy)
                r_overrun <= 1'b1;
            case (r_state)
                ST_INIT: begin
                    r_x[r_idx]     <= w_new_x;
                    r_y[r_idx]     <= w_init_y;
                    r_valid[r_idx] <= 1'b1;
                    r_idx          <= r_idx + 1'b1;
                end
                ST_WAIT: begin
                    if (w_frame_evt) begin
                        r_scroll <= w_scroll_sat;
                        r_idx    <= '0;
                    end
                end
                ST_UPDATE: begin
                    if (w_wrap) begin
                        r_y[r_idx]     <= coord_t'(w_t - 10'(Y_BOTTOM + 1));
                        r_x[r_idx]     <= w_new_x;
                        r_valid[r_idx] <= w_resp_valid;
                        if (r_score != 12'hFFF)
                            r_score <= r_score + 12'd1;
                    end else begin
                        r_y[r_idx] <= w_t[8:0];
                    end
                    r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PLAT; i++) begin : g_pack
        assign bus.plat_x[9*i +: 9] = r_x[i];
        assign bus.plat_y[9*i +: 9] = r_y[i];
    end

    assign bus.plat_valid = r_valid;
    assign bus.score      = r_score;
    assign bus.busy       = w_busy;
    assign bus.frame_done = (r_state == ST_DONE);
    assign bus.overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_plat_scheduler.sv
`default_nettype none
// ============================================================================
// Module    : tb_plat_scheduler
// Purpose   : Self-checking bench for plat_scheduler against a frame-level model.
// Revision  : 1.0
// ============================================================================
module tb_plat_scheduler;
    import doodle_pkg::*;

    localparam int NP = 16;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #10 Clk = ~Clk;

    plat_scheduler_if #(.NUM_PLAT(NP)) ifc ();

    plat_scheduler #(.NUM_PLAT(NP)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (ifc)
    );

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    int          mx [NP];
    int          my [NP];
    bit          mv [NP];
    int          mscore;
    logic [15:0] ml;
    bit          mskip;

    function automatic logic [15:0] lfsr_next(logic [15:0] v);
        logic fb;
        fb = v[16-1] ^ v[14-1] ^ v[13-1] ^ v[11-1];
        return {v[14:0], fb};
    endfunction

    function automatic int xgen(logic [15:0] v);
        int r;
        r = int'(v[8:0]);
        return (r <= 447) ? r : r - 448;
    endfunction

    task automatic model_init();
        ml     = LFSR_SEED;
        mscore = 0;
        mskip  = 0;
        for (int i = 0; i < NP; i++) begin
            mx[i] = xgen(ml);
            ml    = lfsr_next(ml);
            my[i] = 480 - 30 * (i + 1);
            mv[i] = 1;
        end
    endtask

    task automatic model_frame(input int scroll, input int diff);
        int  s, t;
        bit  cand;
        s = (scroll > 31) ? 31 : scroll;
        for (int i = 0; i < NP; i++) begin
            t = my[i] + s;
            if (t <= 479) begin
                my[i] = t;
            end else begin
                my[i] = t - 480;
                mx[i] = xgen(ml);
`ifdef PLAT_SKIP_EN
                if (diff == 1)      cand = (ml[15:14] == 2'b00);
                else if (diff >= 2) cand = (ml[15] == 1'b0);
                else                cand = 0;
                if (cand && !mskip) begin mv[i] = 0; mskip = 1; end
                else                begin mv[i] = 1; mskip = 0; end
`else
                cand  = (diff < 0);
                mv[i] = !cand;
`endif
                ml = lfsr_next(ml);
                if (mscore < 4095) mscore++;
            end
        end
    endtask

    function automatic logic [NP*9-1:0] pack_x();
        logic [NP*9-1:0] p;
        for (int i = 0; i < NP; i++) p[9*i +: 9] = 9'(mx[i]);
        return p;
    endfunction

    function automatic logic [NP*9-1:0] pack_y();
        logic [NP*9-1:0] p;
        for (int i = 0; i < NP; i++) p[9*i +: 9] = 9'(my[i]);
        return p;
    endfunction

    function automatic logic [NP-1:0] pack_v();
        logic [NP-1:0] p;
        for (int i = 0; i < NP; i++) p[i] = mv[i];
        return p;
    endfunction

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        assert (got === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_layout(input string tag);
        check({tag, ".x"},     160'(ifc.plat_x),     160'(pack_x()));
        check({tag, ".y"},     160'(ifc.plat_y),     160'(pack_y()));
        check({tag, ".valid"}, 160'(ifc.plat_valid), 160'(pack_v()));
        check({tag, ".score"}, 160'(ifc.score),      160'(mscore));
    endtask

    task automatic start_pulse();
        @(negedge Clk) ifc.start = 1'b1;
        @(negedge Clk) ifc.start = 1'b0;
        model_init();
    endtask

    task automatic wait_init();
        repeat (16) @(posedge Clk);
        @(negedge Clk);
    endtask

    // Falling frame_clk edge, then wait (bounded) for frame_done
    task automatic run_frame(input int scroll, input int diff, output int lat);
        @(negedge Clk);
        ifc.scroll     = 6'(scroll);
        ifc.difficulty = 2'(diff);
        ifc.frame_clk  = 1'b0;
        lat = 0;
        do begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end while (ifc.frame_done !== 1'b1 && lat < 60);
        ifc.frame_clk = 1'b1;
        model_frame(scroll, diff);
        repeat (2) @(negedge Clk);
    endtask

    int lat;
    int pulses;
    int viol;
    bit prev_invalid;
    logic [NP*9-1:0] old_y;

    initial begin
        ifc.frame_clk  = 1'b1;
        ifc.start      = 1'b0;
        ifc.scroll     = '0;
        ifc.difficulty = '0;

        repeat (2) @(negedge Clk);
        check("rst.x",       160'(ifc.plat_x),     160'(0));
        check("rst.y",       160'(ifc.plat_y),     160'(0));
        check("rst.valid",   160'(ifc.plat_valid), 160'(0));
        check("rst.score",   160'(ifc.score),      160'(0));
        check("rst.busy",    160'(ifc.busy),       160'(0));
        check("rst.done",    160'(ifc.frame_done), 160'(0));
        check("rst.overrun", 160'(ifc.overrun),    160'(0));
        Reset_n = 1'b1;

        // Frame event in IDLE must be ignored
        @(negedge Clk) ifc.frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
        ifc.frame_clk = 1'b1;
        check("idle.busy",    160'(ifc.busy),    160'(0));
        check("idle.overrun", 160'(ifc.overrun), 160'(0));
        repeat (3) @(negedge Clk);

        start_pulse();
        check("init.busy_during", 160'(ifc.busy), 160'(1));
        wait_init();
        check("init.y0",   160'(ifc.plat_y[8:0]),      160'(450));
        check("init.y15",  160'(ifc.plat_y[143:135]),  160'(0));
        check("init.busy", 160'(ifc.busy),             160'(0));
        check_layout("init");

        run_frame(31, 0, lat);
        check("f1.latency_ok", 160'(lat >= 18 && lat <= 21), 160'(1));
        check("f1.y0",    160'(ifc.plat_y[8:0]),  160'(1));
        check("f1.y1",    160'(ifc.plat_y[17:9]), 160'(451));
        check("f1.score", 160'(ifc.score),        160'(1));
        check_layout("f1");

        run_frame(50, 0, lat);
        check("f2.y1",    160'(ifc.plat_y[17:9]), 160'(2));
        check("f2.score", 160'(ifc.score),        160'(2));
        check_layout("f2");

        run_frame(0, 0, lat);
        check("f0.done_seen", 160'(lat < 60), 160'(1));
        check_layout("f0");

        // Second frame edge lands during UPDATE: dropped, overrun set
        @(negedge Clk);
        ifc.scroll    = 6'd5;
        ifc.frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        ifc.frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        ifc.frame_clk = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            if (i == 4) ifc.frame_clk = 1'b1;
            if (ifc.frame_done === 1'b1) pulses++;
        end
        model_frame(5, 0);
        check("ovr.flag",   160'(ifc.overrun), 160'(1));
        check("ovr.pulses", 160'(pulses),      160'(1));
        check_layout("ovr");

        // start in the middle of an update aborts it
        @(negedge Clk);
        ifc.scroll    = 6'd31;
        ifc.frame_clk = 1'b0;
        repeat (8) @(negedge Clk);
        ifc.frame_clk = 1'b1;
        check("abort.busy_before", 160'(ifc.busy), 160'(1));
        start_pulse();
        check("abort.busy_init",   160'(ifc.busy),    160'(1));
        check("abort.overrun",     160'(ifc.overrun), 160'(0));
        wait_init();
        check("abort.busy_after",  160'(ifc.busy),    160'(0));
        check_layout("abort");

        // Randomised scroll and difficulty
        for (int f = 0; f < 40; f++) begin
            run_frame(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), lat);
            check("rnd.done_seen", 160'(lat < 60), 160'(1));
            check_layout("rnd");
        end

        // Hard difficulty soak: never two invalid respawns back to back
        start_pulse();
        wait_init();
        viol = 0;
        prev_invalid = 0;
        for (int f = 0; f < 200; f++) begin
            old_y = ifc.plat_y;
            run_frame(31, 3, lat);
            for (int i = 0; i < NP; i++) begin
                if (ifc.plat_y[9*i +: 9] < old_y[9*i +: 9]) begin
                    if (!ifc.plat_valid[i] && prev_invalid) viol++;
                    prev_invalid = !ifc.plat_valid[i];
                end
            end
            check_layout("hard");
`ifndef PLAT_SKIP_EN
            check("hard.all_valid", 160'(ifc.plat_valid), 160'({NP{1'b1}}));
`endif
        end
        check("hard.no_double_skip", 160'(viol), 160'(0));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
`default_nettype wire
